multiport_register_file: RTL and testbench

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

---
 rtl/multiport_register_file.sv | 121 ++++++++++++
 tb/tb_multiport_register_file.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_register_file.sv
// Two-write, two-read register file with per-register busy (reservation) bits.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module multiport_register_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic [ADDR_W:0]   busy_count
);

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam bit          ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0]   regs_q   [NUM_REGS];
  logic [DATA_W-1:0]   fwd_data [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] legal;
  logic [NUM_REGS-1:0] hit_a;
  logic [NUM_REGS-1:0] hit_b;
  logic [NUM_REGS-1:0] hit_r;
  logic [CNT_W-1:0]    busy_cnt;

  // Per-register decode; addresses >= NUM_REGS never match, so they are dropped.
  always_comb begin
    legal = '0;
    hit_a = '0;
    hit_b = '0;
    hit_r = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      legal[i] = !(ZERO_EN && (i == 0));
      hit_a[i] = legal[i] && wr_en_a    && (wr_addr_a    == ADDR_W'(i));
      hit_b[i] = legal[i] && wr_en_b    && (wr_addr_b    == ADDR_W'(i));
      hit_r[i] = legal[i] && reserve_en && (reserve_addr == ADDR_W'(i));
    end
  end

  // Port B is applied last so it wins a same-address collision; a reservation
  // on the same edge as a write keeps the register busy for the new producer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (hit_b[i]) begin
          regs_q[i] <= wr_data_b;
        end else if (hit_a[i]) begin
          regs_q[i] <= wr_data_a;
        end
        if (hit_r[i]) begin
          busy_q[i] <= 1'b1;
        end else if (hit_a[i] || hit_b[i]) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  // Value presented to the read mux for each register.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      fwd_data[i] = regs_q[i];
`ifdef REGFILE_BYPASS_EN
      if (hit_b[i]) begin
        fwd_data[i] = wr_data_b;
      end else if (hit_a[i]) begin
        fwd_data[i] = wr_data_a;
      end
`endif
    end
  end

  // Read ports: zero for reset, the zero register and unimplemented addresses.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    rd_busy1 = 1'b0;
    rd_busy2 = 1'b0;
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (legal[i] && (rd_addr1 == ADDR_W'(i))) begin
          rd_data1 = fwd_data[i];
          rd_busy1 = busy_q[i];
        end
        if (legal[i] && (rd_addr2 == ADDR_W'(i))) begin
          rd_data2 = fwd_data[i];
          rd_busy2 = busy_q[i];
        end
      end
    end
  end

  // Population count of the reservation bits.
  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_cnt = busy_cnt + CNT_W'(busy_q[i]);
    end
    busy_count = rst ? '0 : busy_cnt;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench for multiport_register_file: a 32-entry instance plus a
// 24-entry instance sharing the same stimulus for out-of-range behaviour.
module tb_multiport_register_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rd_addr1 = '0, rd_addr2 = '0;
  logic          wr_en_a = 1'b0, wr_en_b = 1'b0, reserve_en = 1'b0;
  logic [AW-1:0] wr_addr_a = '0, wr_addr_b = '0, reserve_addr = '0;
  logic [DW-1:0] wr_data_a = '0, wr_data_b = '0;

  logic [DW-1:0] rd_data1, rd_data2, rd_data1_s, rd_data2_s;
  logic          rd_busy1, rd_busy2, rd_busy1_s, rd_busy2_s;
  logic [AW:0]   busy_count, busy_count_s;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_v;
  logic [DW-1:0] mem [32];

  always #5 clk = ~clk;

  multiport_register_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .reserve_en(reserve_en), .reserve_addr(reserve_addr),
    .busy_count(busy_count)
  );

  multiport_register_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(24), .ZERO_REG(1)) u_dut24 (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1_s), .rd_data2(rd_data2_s),
    .rd_busy1(rd_busy1_s), .rd_busy2(rd_busy2_s),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .reserve_en(reserve_en), .reserve_addr(reserve_addr),
    .busy_count(busy_count_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en_a    = 1'b0;
    wr_en_b    = 1'b0;
    reserve_en = 1'b0;
  endtask

  task automatic test_reset();
    rd_addr1 = AW'(5);
    #12;
    exp_q.push_back('0);
    exp_q.push_back('0);
    exp_v = exp_q.pop_front(); n_tests++;
    if (rd_data1 !== exp_v) begin n_fail++; $display("FAIL reset_rd_data1 got %h exp %h", rd_data1, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(busy_count) !== exp_v) begin n_fail++; $display("FAIL reset_busy_count got %0d exp %0d", busy_count, exp_v); end
    n_tests++;
    if (rd_busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_rd_busy1 got %b exp 0", rd_busy1); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_bulk_write();
    for (int n = 1; n < 32; n++) begin
      wr_en_a = 1'b1; wr_addr_a = AW'(n); wr_data_a = DW'(10 * n);
      mem[n] = DW'(10 * n);
      step();
    end
    idle();
    rd_addr1 = AW'(15); rd_addr2 = AW'(0);
    exp_q.push_back(32'd150);
    exp_q.push_back(32'd0);
    #1;
    exp_v = exp_q.pop_front(); n_tests++;
    if (rd_data1 !== exp_v) begin n_fail++; $display("FAIL bulk_r15 got %0d exp %0d", rd_data1, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (rd_data2 !== exp_v) begin n_fail++; $display("FAIL bulk_r0 got %0d exp %0d", rd_data2, exp_v); end
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = AW'(i);
      exp_q.push_back(mem[i]);
      exp_q.push_back((i < 24) ? mem[i] : '0);
      #1;
      exp_v = exp_q.pop_front(); n_tests++;
      if (rd_data1 !== exp_v) begin n_fail++; $display("FAIL bulk_sweep r%0d got %h exp %h", i, rd_data1, exp_v); end
      exp_v = exp_q.pop_front(); n_tests++;
      if (rd_data1_s !== exp_v) begin n_fail++; $display("FAIL bulk_sweep24 r%0d got %h exp %h", i, rd_data1_s, exp_v); end
    end
  endtask

  task automatic test_collision();
    wr_en_a = 1'b1; wr_addr_a = AW'(5); wr_data_a = 32'hAAAA;
    wr_en_b = 1'b1; wr_addr_b = AW'(5); wr_data_b = 32'hBBBB;
    mem[5] = 32'hBBBB;
    step();
    wr_addr_a = AW'(6); wr_data_a = 32'h66;
    wr_addr_b = AW'(8); wr_data_b = 32'h88;
    mem[6] = 32'h66; mem[8] = 32'h88;
    step();
    idle();
    foreach (exp_v[k]) ;
    for (int i = 5; i <= 8; i++) begin
      rd_addr2 = AW'(i);
      exp_q.push_back(mem[i]);
      #1;
      exp_v = exp_q.pop_front(); n_tests++;
      if (rd_data2 !== exp_v) begin n_fail++; $display("FAIL collision r%0d got %h exp %h", i, rd_data2, exp_v); end
    end
  endtask

  task automatic test_scoreboard();
    reserve_en = 1'b1; reserve_addr = AW'(7); step();
    reserve_addr = AW'(9); step();
    idle();
    rd_addr1 = AW'(7);
    exp_q.push_back(32'd2); exp_q.push_back(32'd1);
    #1;
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(busy_count) !== exp_v) begin n_fail++; $display("FAIL sb_count_two got %0d exp %0d", busy_count, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(rd_busy1) !== exp_v) begin n_fail++; $display("FAIL sb_busy_r7 got %b exp %0d", rd_busy1, exp_v); end
    reserve_en = 1'b1; reserve_addr = AW'(7); step(); idle();
    exp_q.push_back(32'd2);
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(busy_count) !== exp_v) begin n_fail++; $display("FAIL sb_rereserve got %0d exp %0d", busy_count, exp_v); end
    wr_en_a = 1'b1; wr_addr_a = AW'(7); wr_data_a = 32'h77; mem[7] = 32'h77;
    step(); idle();
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(rd_busy1) !== exp_v) begin n_fail++; $display("FAIL sb_write_clear got %b exp %0d", rd_busy1, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(busy_count) !== exp_v) begin n_fail++; $display("FAIL sb_count_one got %0d exp %0d", busy_count, exp_v); end
    reserve_en = 1'b1; reserve_addr = AW'(9);
    wr_en_b = 1'b1; wr_addr_b = AW'(9); wr_data_b = 32'h99; mem[9] = 32'h99;
    step(); idle();
    rd_addr2 = AW'(9);
    exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'h99); exp_q.push_back(32'd1);
    #1;
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(rd_busy2) !== exp_v) begin n_fail++; $display("FAIL sb_res_wr_busy got %b exp %0d", rd_busy2, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(busy_count) !== exp_v) begin n_fail++; $display("FAIL sb_res_wr_count got %0d exp %0d", busy_count, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (rd_data2 !== exp_v) begin n_fail++; $display("FAIL sb_res_wr_data got %h exp %h", rd_data2, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(busy_count_s) !== exp_v) begin n_fail++; $display("FAIL sb_count24 got %0d exp %0d", busy_count_s, exp_v); end
    reserve_en = 1'b1; reserve_addr = AW'(0);
    wr_en_a = 1'b1; wr_addr_a = AW'(0); wr_data_a = 32'h5;
    step(); idle();
    rd_addr1 = AW'(0);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(busy_count) !== exp_v) begin n_fail++; $display("FAIL sb_r0_count got %0d exp %0d", busy_count, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(rd_busy1) !== exp_v) begin n_fail++; $display("FAIL sb_r0_busy got %b exp %0d", rd_busy1, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (rd_data1 !== exp_v) begin n_fail++; $display("FAIL sb_r0_data got %h exp %h", rd_data1, exp_v); end
  endtask

  task automatic test_bypass();
    rd_addr2 = AW'(3);
    wr_en_a = 1'b1; wr_addr_a = AW'(3); wr_data_a = 32'h1234;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'h1234);
`else
    exp_q.push_back(mem[3]);
`endif
    #1;
    exp_v = exp_q.pop_front(); n_tests++;
    if (rd_data2 !== exp_v) begin n_fail++; $display("FAIL bypass_pre_edge got %h exp %h", rd_data2, exp_v); end
    mem[3] = 32'h1234;
    step(); idle();
    exp_q.push_back(32'h1234);
    exp_v = exp_q.pop_front(); n_tests++;
    if (rd_data2 !== exp_v) begin n_fail++; $display("FAIL bypass_post_edge got %h exp %h", rd_data2, exp_v); end
    wr_en_a = 1'b1; wr_addr_a = AW'(3); wr_data_a = 32'hA3;
    wr_en_b = 1'b1; wr_addr_b = AW'(3); wr_data_b = 32'hB3;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'hB3);
`else
    exp_q.push_back(mem[3]);
`endif
    #1;
    exp_v = exp_q.pop_front(); n_tests++;
    if (rd_data2 !== exp_v) begin n_fail++; $display("FAIL bypass_both_ports got %h exp %h", rd_data2, exp_v); end
    mem[3] = 32'hB3;
    step(); idle();
    exp_q.push_back(32'hB3);
    exp_v = exp_q.pop_front(); n_tests++;
    if (rd_data2 !== exp_v) begin n_fail++; $display("FAIL bypass_both_post got %h exp %h", rd_data2, exp_v); end
  endtask

  task automatic test_reset_mid();
    wr_en_a = 1'b1; wr_addr_a = AW'(4); wr_data_a = 32'h55; step();
    idle(); reserve_en = 1'b1; reserve_addr = AW'(4); step(); idle();
    rd_addr1 = AW'(4);
    exp_q.push_back(32'h55); exp_q.push_back(32'd2);
    #1;
    exp_v = exp_q.pop_front(); n_tests++;
    if (rd_data1 !== exp_v) begin n_fail++; $display("FAIL rstmid_pre_data got %h exp %h", rd_data1, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(busy_count) !== exp_v) begin n_fail++; $display("FAIL rstmid_pre_count got %0d exp %0d", busy_count, exp_v); end
    #2;
    rst = 1'b1;
    wr_en_a = 1'b1; wr_addr_a = AW'(4); wr_data_a = 32'h77;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    exp_v = exp_q.pop_front(); n_tests++;
    if (rd_data1 !== exp_v) begin n_fail++; $display("FAIL rstmid_data got %h exp %h", rd_data1, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(busy_count) !== exp_v) begin n_fail++; $display("FAIL rstmid_count got %0d exp %0d", busy_count, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(rd_busy1) !== exp_v) begin n_fail++; $display("FAIL rstmid_busy got %b exp %0d", rd_busy1, exp_v); end
    step();
    @(negedge clk);
    idle();
    rst = 1'b0;
    step();
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = AW'(i);
      exp_q.push_back(mem[i]);
      #1;
      exp_v = exp_q.pop_front(); n_tests++;
      if (rd_data1 !== exp_v) begin n_fail++; $display("FAIL rstmid_lost r%0d got %h exp %h", i, rd_data1, exp_v); end
    end
    exp_q.push_back(32'd0);
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(busy_count) !== exp_v) begin n_fail++; $display("FAIL rstmid_post_count got %0d exp %0d", busy_count, exp_v); end
  endtask

  task automatic test_out_of_range();
    wr_en_a = 1'b1; wr_addr_a = AW'(12); wr_data_a = 32'hC12; mem[12] = 32'hC12;
    step();
    wr_addr_a = AW'(30); wr_data_a = 32'hDEAD; mem[30] = 32'hDEAD;
    reserve_en = 1'b1; reserve_addr = AW'(30);
    step(); idle();
    rd_addr1 = AW'(30);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'hDEAD); exp_q.push_back(32'd1);
    #1;
    exp_v = exp_q.pop_front(); n_tests++;
    if (rd_data1_s !== exp_v) begin n_fail++; $display("FAIL oor_data got %h exp %h", rd_data1_s, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(rd_busy1_s) !== exp_v) begin n_fail++; $display("FAIL oor_busy got %b exp %0d", rd_busy1_s, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(busy_count_s) !== exp_v) begin n_fail++; $display("FAIL oor_count got %0d exp %0d", busy_count_s, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (rd_data1 !== exp_v) begin n_fail++; $display("FAIL oor_full_r30 got %h exp %h", rd_data1, exp_v); end
    exp_v = exp_q.pop_front(); n_tests++;
    if (DW'(busy_count) !== exp_v) begin n_fail++; $display("FAIL oor_full_count got %0d exp %0d", busy_count, exp_v); end
    for (int i = 0; i < 24; i++) begin
      rd_addr2 = AW'(i);
      exp_q.push_back(mem[i]);
      #1;
      exp_v = exp_q.pop_front(); n_tests++;
      if (rd_data2_s !== exp_v) begin n_fail++; $display("FAIL oor_unchanged r%0d got %h exp %h", i, rd_data2_s, exp_v); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_bulk_write();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_reset_mid();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
